// File: rtl/coco_sd_responder.sv
// -----------------------------------------------------------------------------
// coco_sd_responder
//
// Serves 512-byte block reads and writes for four virtual SD drives out of a
// shared byte-wide backing memory. Drives are arbitrated round-robin; each
// block is moved one byte at a time between the drive's buffer and memory at
//    MEM_BASE + {drive[1:0], lba[10:0], byte[8:0]}.
// Blocks beyond lba 2047 never reach memory: reads return zeros and writes
// are dropped, but the drive still sees a full 512-byte transfer.
//
// Ports
//    CLK, RESET_N             clock (rising edge), async active-low reset
//    sd_lba_0..3              block address per drive
//    sd_rd, sd_wr             per-drive read / write request levels
//    sd_ack                   one-hot acknowledge of the drive being served
//    sd_buff_addr             byte index inside the block
//    sd_buff_dout, sd_buff_wr read byte and its one-cycle write strobe
//    sd_buff_din_0..3         drive buffer read data (2-cycle latency)
//    mem_addr, mem_rd, mem_wr backing-memory request, held until mem_ready
//    mem_wdata, mem_rdata     memory write / read data
//    mem_ready                request accepted; mem_rdata valid this cycle
// -----------------------------------------------------------------------------
module coco_sd_responder #(
   parameter int unsigned       MEM_AW   = 25,
   parameter logic [MEM_AW-1:0] MEM_BASE = MEM_AW'(25'h0000000)
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic [31:0]       sd_lba_0,
   input  logic [31:0]       sd_lba_1,
   input  logic [31:0]       sd_lba_2,
   input  logic [31:0]       sd_lba_3,
   input  logic [3:0]        sd_rd,
   input  logic [3:0]        sd_wr,
   output logic [3:0]        sd_ack,
   output logic [8:0]        sd_buff_addr,
   output logic [7:0]        sd_buff_dout,
   output logic              sd_buff_wr,
   input  logic [7:0]        sd_buff_din_0,
   input  logic [7:0]        sd_buff_din_1,
   input  logic [7:0]        sd_buff_din_2,
   input  logic [7:0]        sd_buff_din_3,
   output logic [MEM_AW-1:0] mem_addr,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata,
   input  logic              mem_ready
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACK,
      S_RD_REQ,
      S_RD_PUSH,
      S_WR_ADDR,
      S_WR_SAMPLE,
      S_WR_REQ,
      S_DONE
   } state_t;

   state_t      state_reg;
   logic [1:0]  rr_ptr_reg;
   logic [1:0]  drive_reg;
   logic        op_wr_reg;
   logic [10:0] lba_reg;
   logic        oob_reg;

   logic [31:0] lba_in [4];
   logic [7:0]  din_in [4];
   logic [3:0]  pending;
   logic        pick_valid;
   logic [1:0]  pick_idx;
   logic [1:0]  cand;
   logic [8:0]  addr_next;
   logic        last_byte;

   assign lba_in[0] = sd_lba_0;
   assign lba_in[1] = sd_lba_1;
   assign lba_in[2] = sd_lba_2;
   assign lba_in[3] = sd_lba_3;
   assign din_in[0] = sd_buff_din_0;
   assign din_in[1] = sd_buff_din_1;
   assign din_in[2] = sd_buff_din_2;
   assign din_in[3] = sd_buff_din_3;

   assign pending   = sd_rd | sd_wr;
   assign addr_next = sd_buff_addr + 9'd1;
   assign last_byte = (sd_buff_addr == 9'd511);

   // Round-robin pick: scan from the farthest offset down so the drive
   // closest to rr_ptr is the one left standing.
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = rr_ptr_reg;
      cand       = rr_ptr_reg;
      for (int i = 3; i >= 0; i--) begin
         cand = rr_ptr_reg + 2'(i);
         if (pending[cand]) begin
            pick_valid = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   function automatic logic [MEM_AW-1:0] block_addr(input logic [1:0]  drv,
                                                    input logic [10:0] lba,
                                                    input logic [8:0]  idx);
      logic [21:0] offset;
      offset = {drv, lba, idx};
      return MEM_BASE + MEM_AW'(offset);
   endfunction

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_reg    <= S_IDLE;
         rr_ptr_reg   <= 2'd0;
         drive_reg    <= 2'd0;
         op_wr_reg    <= 1'b0;
         lba_reg      <= 11'd0;
         oob_reg      <= 1'b0;
         sd_ack       <= 4'd0;
         sd_buff_addr <= 9'd0;
         sd_buff_dout <= 8'd0;
         sd_buff_wr   <= 1'b0;
         mem_addr     <= '0;
         mem_rd       <= 1'b0;
         mem_wr       <= 1'b0;
         mem_wdata    <= 8'd0;
      end else begin
         sd_buff_wr <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (pick_valid) begin
                  drive_reg    <= pick_idx;
                  op_wr_reg    <= sd_wr[pick_idx];
                  lba_reg      <= lba_in[pick_idx][10:0];
                  oob_reg      <= |lba_in[pick_idx][31:11];
                  rr_ptr_reg   <= pick_idx + 2'd1;
                  sd_buff_addr <= 9'd0;
                  mem_addr     <= block_addr(pick_idx, lba_in[pick_idx][10:0], 9'd0);
                  sd_ack       <= 4'b0001 << pick_idx;
                  state_reg    <= S_ACK;
               end
            end

            S_ACK: begin
               if (op_wr_reg) begin
                  state_reg <= S_WR_ADDR;
               end else begin
                  mem_rd    <= !oob_reg;
                  state_reg <= S_RD_REQ;
               end
            end

            S_RD_REQ: begin
               if (oob_reg) begin
                  sd_buff_dout <= 8'h00;
                  sd_buff_wr   <= 1'b1;
                  state_reg    <= S_RD_PUSH;
               end else if (mem_ready) begin
                  mem_rd       <= 1'b0;
                  sd_buff_dout <= mem_rdata;
                  sd_buff_wr   <= 1'b1;
                  state_reg    <= S_RD_PUSH;
               end
            end

            S_RD_PUSH: begin
               if (last_byte) begin
                  state_reg <= S_DONE;
               end else begin
                  sd_buff_addr <= addr_next;
                  mem_addr     <= block_addr(drive_reg, lba_reg, addr_next);
                  mem_rd       <= !oob_reg;
                  state_reg    <= S_RD_REQ;
               end
            end

            // One dead cycle gives the drive buffer its read latency before
            // WR_SAMPLE takes the byte.
            S_WR_ADDR: state_reg <= S_WR_SAMPLE;

            S_WR_SAMPLE: begin
               mem_wdata <= din_in[drive_reg];
               mem_wr    <= !oob_reg;
               state_reg <= S_WR_REQ;
            end

            S_WR_REQ: begin
               if (oob_reg || mem_ready) begin
                  mem_wr <= 1'b0;
                  if (last_byte) begin
                     state_reg <= S_DONE;
                  end else begin
                     sd_buff_addr <= addr_next;
                     mem_addr     <= block_addr(drive_reg, lba_reg, addr_next);
                     state_reg    <= S_WR_ADDR;
                  end
               end
            end

            // Ack drops as DONE is left, so back-to-back blocks show exactly
            // one low cycle (the IDLE cycle) between acknowledges.
            S_DONE: begin
               sd_ack    <= 4'd0;
               state_reg <= S_IDLE;
            end

            default: state_reg <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/coco_sd_responder.md
COCO_SD_RESPONDER -- requirements
Module: coco_sd_responder

Interface
REQ-001 Parameter MEM_BASE, default 25'h0000000, byte base address of the four-drive image region in backing memory.
REQ-002 Parameter MEM_AW, default 25, width of mem_addr.
REQ-003 CLK  in  1  system clock; all logic on rising edge.
REQ-004 RESET_N  in  1  reset, asynchronous, active-low.
REQ-005 sd_lba_0..sd_lba_3  in  32 each  block address requested by drive n.
REQ-006 sd_rd  in  4  per-drive block read request, level.
REQ-007 sd_wr  in  4  per-drive block write request, level.
REQ-008 sd_ack  out  4  per-drive acknowledge; at most one bit high.
REQ-009 sd_buff_addr  out  9  byte index within the 512-byte block.
REQ-010 sd_buff_dout  out  8  read data toward the drive buffer.
REQ-011 sd_buff_wr  out  1  one-cycle write strobe for sd_buff_dout.
REQ-012 sd_buff_din_0..sd_buff_din_3  in  8 each  drive buffer output; valid 2 cycles after sd_buff_addr changes.
REQ-013 mem_addr  out  MEM_AW  backing-memory byte address.
REQ-014 mem_rd, mem_wr  out  1 each  memory request, held until mem_ready.
REQ-015 mem_wdata  out  8; mem_rdata  in  8; mem_ready  in  1  (ready and rdata valid in same cycle).

Function
REQ-016 The block SHALL implement states IDLE, ACK, RD_REQ, RD_PUSH, WR_ADDR, WR_SAMPLE, WR_REQ, DONE.
REQ-017 In IDLE, for pending = sd_rd|sd_wr nonzero, the block SHALL pick a drive by round-robin starting at rr_ptr, then set rr_ptr = picked+1 (mod 4).
REQ-018 On pick it SHALL latch drive index, op (write if sd_wr[n], else read; write wins when both set) and lba from sd_lba_n, set sd_buff_addr=0, and enter ACK.
REQ-019 ACK SHALL assert sd_ack[n] and hold it through DONE; next state RD_REQ or WR_ADDR.
REQ-020 mem_addr SHALL equal MEM_BASE + {n[1:0], lba[10:0], sd_buff_addr[8:0]} truncated to MEM_AW.
REQ-021 If lba[31:11] nonzero, the block SHALL not touch memory: reads return 8'h00 per byte, writes are discarded; ack sequence and byte count unchanged.
REQ-022 RD_REQ SHALL hold mem_rd until mem_ready, capture mem_rdata into sd_buff_dout, enter RD_PUSH.
REQ-023 RD_PUSH SHALL pulse sd_buff_wr one cycle; if sd_buff_addr=511 go DONE, else increment sd_buff_addr and return RD_REQ.
REQ-024 WR_ADDR SHALL wait one cycle; WR_SAMPLE SHALL capture sd_buff_din_n into mem_wdata (2 cycles after address); WR_REQ SHALL hold mem_wr until mem_ready, then go DONE at 511 or increment sd_buff_addr and return WR_ADDR.
REQ-025 mem_rd and mem_wr SHALL never be high together; addr/wdata SHALL stay stable while a request is held.
REQ-026 DONE SHALL deassert sd_ack for one cycle, then return IDLE; a drive whose request is still high is re-arbitrated normally.
REQ-027 Exactly 512 sd_buff_wr pulses per read block; exactly 512 mem_wr handshakes per write block.
REQ-028 Request changes on the active drive after pick SHALL be ignored until DONE.

Reset
REQ-029 RESET_N low SHALL force, asynchronously and mid-transfer: state IDLE, sd_ack=0, sd_buff_wr=0, sd_buff_addr=0, sd_buff_dout=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0, rr_ptr=0.
REQ-030 After release, no memory request SHALL issue until a new sd_rd/sd_wr is picked.

Verification
REQ-031 sd_rd=4'b0001, lba_0=3, memory byte k = k[7:0], mem_ready always 1 -> sd_ack[0] high, 512 strobes, addr 0..511, dout = (MEM_BASE+0x600+k)[7:0].
REQ-032 sd_wr=4'b0100, lba_2=1, din_2 = ~addr -> 512 mem_wr at MEM_BASE+0x200000+0x200+k with data ~k[7:0], sd_ack=4'b0100.
REQ-033 sd_rd=4'b1111 held, rr_ptr=0 -> served order drives 0,1,2,3,0; one-cycle ack gap between.
REQ-034 sd_rd[1] and sd_wr[1] both set -> write performed, no mem_rd.
REQ-035 lba_0=32'h800 read -> 512 strobes of 8'h00, zero mem requests; mem_ready random 0-5 cycle stalls on normal read -> data correct, strobes only after ready.
REQ-036 RESET_N low at byte 200 of a write -> all outputs zero same cycle; after release idle until new request.
